rr_stream_mux: RTL and testbench

//   Parametrised successor of the 2:1 mux primitive.

---
 rtl/rr_stream_mux.sv | 93 +++++++++
 tb/tb_rr_stream_mux.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream merge: round-robin grant feeding one registered output stage.
// Latency 1 cycle; in_ready_o is all-zero while the output word stalls or rst_i is high.
module rr_stream_mux #(
  parameter int W = 8,
  parameter int N = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       in_valid_i,
  input  logic [N*W-1:0]     in_data_i,
  output logic [N-1:0]       in_ready_o,
  output logic               out_valid_o,
  output logic [W-1:0]       out_data_o,
  output logic [SEL_W-1:0]   out_sel_o,
  input  logic               out_ready_i
);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [W-1:0]     gnt_dat;
  logic             can_accept;
  logic             accept;

  // Scan distance from the pointer: channel last+1 has distance 0; smallest valid distance wins.
  always_comb begin
    int best;
    int pos;
    best    = N;
    pos     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_dat = '0;
    for (int ch = 0; ch < N; ch++) begin
      pos = (ch + N - 1 - int'(last_q)) % N;
      if (in_valid_i[ch] && (pos < best)) begin
        best    = pos;
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(ch);
        gnt_dat = in_data_i[ch*W +: W];
      end
    end
  end

  assign can_accept = !out_valid_q || out_ready_i;
  assign accept     = gnt_vld && can_accept && !rst_i;

  always_comb begin
    in_ready_o = '0;
    for (int ch = 0; ch < N; ch++) begin
      in_ready_o[ch] = accept && (gnt_idx == SEL_W'(ch));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_dat;
      out_sel_d   = gnt_idx;
      last_d      = gnt_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed and scoreboarded bench for rr_stream_mux (N=4 main instance, N=1 pass-through instance).
module tb_rr_stream_mux;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;

  logic           in_valid1, in_ready1, out_valid1, out_ready1, out_sel1;
  logic [W-1:0]   in_data1, out_data1;

  int checks = 0;
  int errors = 0;

  rr_stream_mux #(.W(W), .N(N)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_sel_o(out_sel),
    .out_ready_i(out_ready)
  );

  rr_stream_mux #(.W(W), .N(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid1), .in_data_i(in_data1), .in_ready_o(in_ready1),
    .out_valid_o(out_valid1), .out_data_o(out_data1), .out_sel_o(out_sel1),
    .out_ready_i(out_ready1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data();
    for (int ch = 0; ch < N; ch++) in_data[ch*W +: W] = 8'hC0 + 8'(ch);
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '1; fill_data(); out_ready = 1'b1;
    in_valid1 = 1'b1; in_data1 = 8'h11; out_ready1 = 1'b1;
    step(); step();
    checks++;
    if ({in_ready, in_ready1} !== 5'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b/%b expected 0000/0", in_ready, in_ready1);
    end
    checks++;
    if ({out_valid, out_sel, out_data} !== 11'b0) begin
      errors++; $display("FAIL reset_outputs: got v=%b sel=%0d data=%h expected 0/0/00", out_valid, out_sel, out_data);
    end
    checks++;
    if ({out_valid1, out_data1} !== 9'b0) begin
      errors++; $display("FAIL reset_n1_outputs: got v=%b data=%h expected 0/00", out_valid1, out_data1);
    end
    rst = 1'b0; in_valid1 = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready);
    end
    step();
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 8'hC0}) begin
      errors++; $display("FAIL reset_first_word: got v=%b sel=%0d data=%h expected 1/0/c0", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_single();
    apply_reset();
    in_data = '0; in_data[2*W +: W] = 8'hA5; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++; $display("FAIL single_in_ready: got %b expected 0100", in_ready);
    end
    step();
    in_valid = '0;
    #1;
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, 8'hA5}) begin
      errors++; $display("FAIL single_out: got v=%b sel=%0d data=%h expected 1/2/a5", out_valid, out_sel, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    apply_reset();
    fill_data(); in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_rdy = 4'b0001 << (i % N);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_grant_%0d: got %b expected %b", i, in_ready, exp_rdy);
      end
      step();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'(i % N), 8'hC0 + 8'(i % N)}) begin
        errors++; $display("FAIL rr_out_%0d: got v=%b sel=%0d data=%h expected 1/%0d", i, out_valid, out_sel, out_data, i % N);
      end
    end
  endtask

  // Follows test_round_robin: output holds channel 3's word, pointer at 3.
  task automatic test_stall();
    out_ready = 1'b0; in_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000 || {out_valid, out_sel, out_data} !== {1'b1, 2'd3, 8'hC3}) begin
        errors++; $display("FAIL stall_%0d: got rdy=%b v=%b sel=%0d data=%h expected 0000/1/3/c3", i, in_ready, out_valid, out_sel, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL stall_release_grant: got %b expected 0010", in_ready);
    end
    step();
    checks++;
    if ({out_sel, out_data} !== {2'd1, 8'hC1} || in_ready !== 4'b1000) begin
      errors++; $display("FAIL stall_after_1: got sel=%0d data=%h rdy=%b expected 1/c1/1000", out_sel, out_data, in_ready);
    end
    step();
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd3, 8'hC3}) begin
      errors++; $display("FAIL stall_after_3: got v=%b sel=%0d data=%h expected 1/3/c3", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    fill_data(); out_ready = 1'b1; in_valid = 4'b0100;
    step();
    in_valid = 4'b0011;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_grant0: got %b expected 0001", in_ready);
    end
    step();
    checks++;
    if (out_sel !== 2'd0 || in_ready !== 4'b0010) begin
      errors++; $display("FAIL wrap_grant1: got sel=%0d rdy=%b expected 0/0010", out_sel, in_ready);
    end
    step();
    in_valid = 4'b1000;
    #1;
    checks++;
    if (out_sel !== 2'd1 || in_ready !== 4'b1000) begin
      errors++; $display("FAIL skip_grant3: got sel=%0d rdy=%b expected 1/1000", out_sel, in_ready);
    end
    step();
    checks++;
    if (out_sel !== 2'd3 || in_ready !== 4'b1000) begin
      errors++; $display("FAIL self_regrant3: got sel=%0d rdy=%b expected 3/1000", out_sel, in_ready);
    end
    step();
    in_valid = '0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_drain: got out_valid=%b expected 0", out_valid);
    end
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL idle_no_rotate: got %b expected 0001", in_ready);
    end
    step();
  endtask

  task automatic test_reset_mid();
    fill_data(); in_valid = '1; out_ready = 1'b1;
    step(); step();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_same_cycle: got rdy=%b v=%b expected 0000/1", in_ready, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_next: got out_valid=%b expected 0", out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_first_grant: got %b expected 0001", in_ready);
    end
    step();
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 8'hC0}) begin
      errors++; $display("FAIL midrst_first_word: got v=%b sel=%0d data=%h expected 1/0/c0", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_n1();
    apply_reset();
    in_valid1 = 1'b1; in_data1 = 8'h3C; out_ready1 = 1'b1;
    #1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL n1_ready: got %b expected 1", in_ready1);
    end
    step();
    in_data1 = 8'h5A;
    #1;
    checks++;
    if ({out_valid1, out_sel1, out_data1, in_ready1} !== {1'b1, 1'b0, 8'h3C, 1'b1}) begin
      errors++; $display("FAIL n1_first: got v=%b sel=%b data=%h rdy=%b expected 1/0/3c/1", out_valid1, out_sel1, out_data1, in_ready1);
    end
    step();
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    step();
    in_valid1 = 1'b1; in_data1 = 8'h77;
    #1;
    checks++;
    if ({out_valid1, out_data1, in_ready1} !== {1'b1, 8'h5A, 1'b0}) begin
      errors++; $display("FAIL n1_stall: got v=%b data=%h rdy=%b expected 1/5a/0", out_valid1, out_data1, in_ready1);
    end
    out_ready1 = 1'b1;
    #1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL n1_release: got %b expected 1", in_ready1);
    end
    step();
    in_valid1 = 1'b0;
    #1;
    checks++;
    if ({out_valid1, out_data1} !== {1'b1, 8'h77}) begin
      errors++; $display("FAIL n1_third: got v=%b data=%h expected 1/77", out_valid1, out_data1);
    end
  endtask

  task automatic test_random();
    logic [5:0]    seq [N];
    int            wait_cnt [N];
    logic [9:0]    expq [$];
    logic [N-1:0]  hs;
    apply_reset();
    in_valid = '0; in_data = '0;
    for (int ch = 0; ch < N; ch++) begin seq[ch] = '0; wait_cnt[ch] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (!in_valid[ch] && ($urandom_range(1, 0) == 1)) begin
          in_valid[ch] = 1'b1;
          in_data[ch*W +: W] = {2'(ch), seq[ch]};
        end
      end
      out_ready = ($urandom_range(9, 0) < 7);
      #1;
      checks++;
      if ((in_ready & ~in_valid) !== 4'b0 || $countones(in_ready) > 1) begin
        errors++; $display("FAIL rnd_ready_shape cyc %0d: got rdy=%b valid=%b", cyc, in_ready, in_valid);
      end
      checks++;
      if (out_valid !== (expq.size() != 0)) begin
        errors++; $display("FAIL rnd_out_valid cyc %0d: got %b expected %b", cyc, out_valid, expq.size() != 0);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_dup cyc %0d: got sel=%0d data=%h expected no word", cyc, out_sel, out_data);
        end else begin
          if ({out_sel, out_data} !== expq[0]) begin
            errors++; $display("FAIL rnd_order cyc %0d: got %h expected %h", cyc, {out_sel, out_data}, expq[0]);
          end
          void'(expq.pop_front());
        end
      end
      hs = in_ready;
      for (int ch = 0; ch < N; ch++) begin
        if (hs[ch]) begin
          expq.push_back({2'(ch), in_data[ch*W +: W]});
          checks++;
          if (wait_cnt[ch] > N - 1) begin
            errors++; $display("FAIL rnd_fairness ch %0d: got %0d other grants expected <= %0d", ch, wait_cnt[ch], N - 1);
          end
          wait_cnt[ch] = 0;
        end else if (in_valid[ch] && (hs != '0)) begin
          wait_cnt[ch]++;
        end
      end
      step();
      for (int ch = 0; ch < N; ch++) begin
        if (hs[ch]) begin in_valid[ch] = 1'b0; seq[ch]++; end
      end
    end
    in_valid = '0; out_ready = 1'b1;
    #1;
    if (out_valid) begin
      checks++;
      if (expq.size() == 0 || {out_sel, out_data} !== expq[0]) begin
        errors++; $display("FAIL rnd_drain_word: got %h expected queued word", {out_sel, out_data});
      end
      if (expq.size() != 0) void'(expq.pop_front());
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || expq.size() != 0) begin
      errors++; $display("FAIL rnd_final: got out_valid=%b pending=%0d expected 0/0", out_valid, expq.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_n1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
